// File: rtl/jtbubl_rom_arb_if.sv
// jtbubl_rom_arb_if: requester A/B cache ports, SDRAM ROM port and timeout pulse; master = arbiter side, slave = requesters/ROM side
interface jtbubl_rom_arb_if #(
  parameter int AW = 18,
  parameter int DW = 32
);
  logic          a_cs;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          a_ok;
  logic          b_cs;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          b_ok;
  logic [AW-1:0] rom_addr;
  logic          rom_cs;
  logic [DW-1:0] rom_data;
  logic          rom_ok;
  logic          tout;
  modport master (
    input  a_cs, a_addr, b_cs, b_addr, rom_data, rom_ok,
    output a_data, a_ok, b_data, b_ok, rom_addr, rom_cs, tout
  );
  modport slave (
    output a_cs, a_addr, b_cs, b_addr, rom_data, rom_ok,
    input  a_data, a_ok, b_data, b_ok, rom_addr, rom_cs, tout
  );
endinterface

// File: rtl/jtbubl_rom_arb.sv
// jtbubl_rom_arb: round-robin arbiter of two cached ROM requesters onto one SDRAM port (clk, rst_n, bus: a_*/b_* requests, rom_* port, tout abort pulse)
module jtbubl_rom_arb #(
  parameter int AW   = 18,
  parameter int DW   = 32,
  parameter int TOUT = 64
) (
  input logic              clk,
  input logic              rst_n,
  jtbubl_rom_arb_if.master bus
);
  typedef enum logic [1:0] {IDLE, BUSY_A, BUSY_B, GAP} state_t;
  state_t        st, st_nx;
  logic          a_valid, b_valid, last_b, rom_cs, tout;
  logic [AW-1:0] a_caddr, b_caddr, rom_addr;
  logic [DW-1:0] a_data, b_data;
  logic [7:0]    cnt;
  logic          a_pend, b_pend, grant_b, busy, done, abort;
  assign bus.a_ok     = bus.a_cs & a_valid & (a_caddr == bus.a_addr);
  assign bus.b_ok     = bus.b_cs & b_valid & (b_caddr == bus.b_addr);
  assign bus.a_data   = a_data;
  assign bus.b_data   = b_data;
  assign bus.rom_addr = rom_addr;
  assign bus.rom_cs   = rom_cs;
  assign bus.tout     = tout;
  assign a_pend  = bus.a_cs & ~bus.a_ok;
  assign b_pend  = bus.b_cs & ~bus.b_ok;
  assign grant_b = b_pend & (~a_pend | ~last_b);
  assign busy    = (st == BUSY_A) | (st == BUSY_B);
  assign done    = busy & bus.rom_ok;
  assign abort   = busy & ~bus.rom_ok & (cnt == 8'(TOUT - 1));
  always_comb begin
    st_nx = st;
    if (st == IDLE)
      st_nx = (a_pend | b_pend) ? (grant_b ? BUSY_B : BUSY_A) : IDLE;
    else if (st == GAP)
      st_nx = IDLE;
    else if (done | abort)
      st_nx = GAP;
  end
  always_ff @(posedge clk)
    st <= !rst_n ? IDLE : st_nx;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      a_valid  <= 1'b0;
      b_valid  <= 1'b0;
      a_caddr  <= '0;
      b_caddr  <= '0;
      a_data   <= '0;
      b_data   <= '0;
      cnt      <= '0;
      tout     <= 1'b0;
      last_b   <= 1'b1;
    end else begin
      tout <= abort;
      if (busy)
        cnt <= cnt + 8'd1;
      if (st == IDLE && st_nx != IDLE) begin
        rom_addr <= grant_b ? bus.b_addr : bus.a_addr;
        rom_cs   <= 1'b1;
        cnt      <= '0;
      end
      if (done | abort) begin
        rom_cs <= 1'b0;
        last_b <= st == BUSY_B;
      end
      if (done && st == BUSY_A) begin
        a_valid <= 1'b1;
        a_caddr <= rom_addr;
        a_data  <= bus.rom_data;
      end
      if (done && st == BUSY_B) begin
        b_valid <= 1'b1;
        b_caddr <= rom_addr;
        b_data  <= bus.rom_data;
      end
    end
  end
endmodule

// File: doc/jtbubl_rom_arb.md
JTBUBL_ROM_ARB -- requirements
Module: jtbubl_rom_arb

Interface
REQ-001 Parameter AW, 18, ROM word address width.
REQ-002 Parameter DW, 32, ROM data width.
REQ-003 Parameter TOUT, 64, maximum cycles in a busy state before abort (range 2..255).
REQ-004 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous and active-low.
REQ-006 a_cs  in  1  requester A (tile fetcher) request; A has first grant after reset.
REQ-007 a_addr  in  AW  requester A word address.
REQ-008 a_data  out  DW  requester A cached data.
REQ-009 a_ok  out  1  A data valid for the current a_addr.
REQ-010 b_cs, b_addr, b_data, b_ok: same as REQ-006..009 for requester B (object fetcher).
REQ-011 rom_addr  out  AW  registered address to the SDRAM ROM port.
REQ-012 rom_cs  out  1  registered request to the SDRAM ROM port.
REQ-013 rom_data  in  DW  SDRAM read data.
REQ-014 rom_ok  in  1  SDRAM data valid for rom_addr.
REQ-015 tout  out  1  one-cycle pulse on busy-state abort.

Function
REQ-016 Each requester x SHALL hold a cache: x_valid bit, x_caddr register (AW), and x_data register (DW).
REQ-017 x_ok SHALL be combinational: x_cs AND x_valid AND (x_caddr == x_addr).
REQ-018 Requester x is pending when x_cs=1 and x_ok=0.
REQ-019 The FSM SHALL have exactly four states: IDLE, BUSY_A, BUSY_B, GAP.
REQ-020 IDLE, only A pending: the FSM goes to BUSY_A.
REQ-021 IDLE, only B pending: the FSM goes to BUSY_B.
REQ-022 IDLE, both pending: grant goes to the requester not in last_grant (round-robin).
REQ-023 IDLE, none pending: the FSM stays in IDLE and rom_cs=0.
REQ-024 On the edge leaving IDLE to BUSY_x: rom_addr<=x_addr, rom_cs<=1, timeout counter<=0.
REQ-025 In BUSY_x with rom_ok=1, on the same edge: x_data<=rom_data, x_caddr<=rom_addr, x_valid<=1, rom_cs<=0, last_grant<=x, next state GAP.
REQ-026 In BUSY_x, a drop of x_cs or a change of x_addr SHALL NOT abort the access; the access completes and the cache stores the original rom_addr, so x_ok reflects the new x_addr match.
REQ-027 In BUSY_x with rom_ok=0, the counter SHALL increment.
REQ-028 When the counter reaches TOUT-1 with rom_ok=0: rom_cs<=0, tout=1 for one cycle, x cache unchanged, last_grant<=x, next state GAP.
REQ-029 GAP SHALL last exactly one cycle with rom_cs=0, then the FSM returns to IDLE.
REQ-030 rom_ok SHALL be ignored in IDLE and GAP.
REQ-031 rom_addr SHALL be held stable during the whole of BUSY_x.
REQ-032 Latency: pending first seen in IDLE at cycle 0; rom_cs=1 from cycle 1; rom_ok at cycle n (n>=1); x_ok=1 from cycle n+1 if x_addr is unchanged.
REQ-033 Back-to-back accesses SHALL be spaced so that the minimum rom_cs low time between them is 2 cycles (GAP then IDLE).
REQ-034 The non-granted requester's cache SHALL never be modified by the other requester's access.
REQ-035 A and B requesting the same address SHALL still produce two separate ROM accesses.

Reset
REQ-036 While rst_n=0 at a clock edge: state<=IDLE; rom_cs<=0; rom_addr<=0; a_valid, b_valid<=0; a_data, b_data, a_caddr, b_caddr<=0; counter<=0; tout<=0; last_grant<=B.
REQ-037 Consequence of REQ-036: a_ok=0 and b_ok=0 during and immediately after reset.
REQ-038 Reset asserted mid-access (BUSY_x) SHALL drop rom_cs on that edge and discard any rom_ok in the same cycle; no cache update occurs.

Verification
REQ-039 Single fetch: after reset, a_cs=1, a_addr=0x00100, rom_ok asserted 3 cycles after rom_cs rises with rom_data=0xDEADBEEF -> rom_addr=0x00100, a_data=0xDEADBEEF, a_ok=1 next cycle, rom_cs low for exactly 1 GAP cycle.
REQ-040 Contention: a_cs=b_cs=1 in the same cycle from reset -> A served first, then B; with both kept re-pending on new addresses, grants alternate A,B,A,B.
REQ-041 Cache hit: after A holds 0x00100, re-request 0x00100 -> a_ok=1 immediately and rom_cs stays 0; change to 0x00101 -> a_ok=0 and a new access starts.
REQ-042 Timeout: b_cs=1, rom_ok never asserted, TOUT=64 -> rom_cs drops after 64 BUSY cycles, tout pulses once, b_ok stays 0, b_cs still high so B is retried after GAP.
REQ-043 Address change mid-access: a_addr changes 0x00200->0x00300 during BUSY_A -> cache stores 0x00200, a_ok=0, then a 0x00300 access follows.
REQ-044 Reset mid-access: rst_n=0 for one cycle during BUSY_B coincident with rom_ok=1 -> rom_cs=0, b_valid=0, next grant goes to A.
